// File: rtl/mem_arbiter_fsm.sv
// rtl/mem_arbiter_fsm.sv - fetch/data arbiter sequencing one transaction at a time onto a shared RAM port
module mem_arbiter_fsm #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              imemRen,
    input  logic [ADDR_W-1:0] imemaddr,
    input  logic              dmmRen,
    input  logic              dmmWen,
    input  logic [ADDR_W-1:0] dmmaddr,
    input  logic [DATA_W-1:0] dmmstore,
    input  logic              busy_o,
    input  logic [DATA_W-1:0] ramload,
    output logic              i_ready,
    output logic              d_ready,
    output logic [DATA_W-1:0] imemload,
    output logic [DATA_W-1:0] dmmload,
    output logic              Ren,
    output logic              Wen,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    state_t            state_q, state_d;
    logic              ren_q, ren_d;
    logic              wen_q, wen_d;
    logic              i_ready_q, i_ready_d;
    logic              d_ready_q, d_ready_d;
    logic              is_data_q, is_data_d;
    logic [3:0]        starve_q, starve_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] store_q, store_d;
    logic [DATA_W-1:0] imemload_q, imemload_d;
    logic [DATA_W-1:0] dmmload_q, dmmload_d;

    logic data_pend;
    logic data_wins;

    assign data_pend = dmmRen | dmmWen;
    // Data normally wins; the starve counter hands fetch a turn once it reaches the limit.
    assign data_wins = data_pend && (!imemRen || (starve_q < LIM));

    always_comb begin
        state_d    = state_q;
        ren_d      = ren_q;
        wen_d      = wen_q;
        i_ready_d  = 1'b0;
        d_ready_d  = 1'b0;
        is_data_d  = is_data_q;
        starve_d   = starve_q;
        addr_d     = addr_q;
        store_d    = store_q;
        imemload_d = imemload_q;
        dmmload_d  = dmmload_q;

        case (state_q)
            IDLE: begin
                if (data_wins) begin
                    state_d   = DACC;
                    is_data_d = 1'b1;
                    addr_d    = dmmaddr;
                    store_d   = dmmWen ? dmmstore : '0;
                    wen_d     = dmmWen;
                    ren_d     = !dmmWen;
                    if (imemRen) begin
                        starve_d = (starve_q >= LIM) ? LIM : starve_q + 4'd1;
                    end else begin
                        starve_d = 4'd0;
                    end
                end else if (imemRen) begin
                    state_d   = IACC;
                    is_data_d = 1'b0;
                    addr_d    = imemaddr;
                    store_d   = '0;
                    wen_d     = 1'b0;
                    ren_d     = 1'b1;
                    starve_d  = 4'd0;
                end
            end
            IACC, DACC: begin
                if (!busy_o) begin
                    state_d = RESP;
                    ren_d   = 1'b0;
                    wen_d   = 1'b0;
                    if (is_data_q) begin
                        d_ready_d = 1'b1;
                        if (!wen_q) begin
                            dmmload_d = ramload;
                        end
                    end else begin
                        i_ready_d  = 1'b1;
                        imemload_d = ramload;
                    end
                end
            end
            // A request still held during its ready cycle must not be re-granted here.
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                ren_d   = 1'b0;
                wen_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q    <= IDLE;
            ren_q      <= 1'b0;
            wen_q      <= 1'b0;
            i_ready_q  <= 1'b0;
            d_ready_q  <= 1'b0;
            is_data_q  <= 1'b0;
            starve_q   <= 4'd0;
            addr_q     <= '0;
            store_q    <= '0;
            imemload_q <= '0;
            dmmload_q  <= '0;
        end else begin
            state_q    <= state_d;
            ren_q      <= ren_d;
            wen_q      <= wen_d;
            i_ready_q  <= i_ready_d;
            d_ready_q  <= d_ready_d;
            is_data_q  <= is_data_d;
            starve_q   <= starve_d;
            addr_q     <= addr_d;
            store_q    <= store_d;
            imemload_q <= imemload_d;
            dmmload_q  <= dmmload_d;
        end
    end

    assign Ren      = ren_q;
    assign Wen      = wen_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;
    assign i_ready  = i_ready_q;
    assign d_ready  = d_ready_q;
    assign imemload = imemload_q;
    assign dmmload  = dmmload_q;

endmodule

// File: tb/tb_mem_arbiter_fsm.sv
// tb/tb_mem_arbiter_fsm.sv - scoreboard bench for mem_arbiter_fsm
module tb_mem_arbiter_fsm;

    logic        clk = 1'b0;
    logic        nRst;
    logic        imemRen, dmmRen, dmmWen;
    logic [31:0] imemaddr, dmmaddr, dmmstore;
    logic        busy_o;
    logic [31:0] ramload;
    logic        i_ready, d_ready, Ren, Wen;
    logic [31:0] imemload, dmmload, ramaddr, ramstore;

    typedef struct packed {
        logic        is_data;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          wait_states = 0;
    int          wait_cnt;
    logic [31:0] mem [0:1023];

    always #5 clk = ~clk;

    mem_arbiter_fsm #(.ADDR_W(32), .DATA_W(32), .STARVE_LIM(4)) dut (
        .clk(clk), .nRst(nRst),
        .imemRen(imemRen), .imemaddr(imemaddr),
        .dmmRen(dmmRen), .dmmWen(dmmWen), .dmmaddr(dmmaddr), .dmmstore(dmmstore),
        .busy_o(busy_o), .ramload(ramload),
        .i_ready(i_ready), .d_ready(d_ready),
        .imemload(imemload), .dmmload(dmmload),
        .Ren(Ren), .Wen(Wen), .ramaddr(ramaddr), .ramstore(ramstore)
    );

    // RAM model: word at byte address A defaults to {A[15:0], ~A[15:0]}
    always @(posedge clk or negedge nRst) begin
        if (!nRst) wait_cnt <= 0;
        else if (Ren | Wen) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end
    assign busy_o  = (Ren | Wen) && (wait_cnt < wait_states);
    assign ramload = mem[ramaddr[11:2]];
    always @(posedge clk) begin
        if (nRst && Wen && !busy_o) mem[ramaddr[11:2]] <= ramstore;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (nRst) begin
            if (Ren | Wen) check("ren_wen_exclusive", {31'd0, Ren & Wen}, 32'd0);
            if (i_ready | d_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_ready: i_ready=%b d_ready=%b with empty scoreboard", i_ready, d_ready);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ready_both", {31'd0, i_ready & d_ready}, 32'd0);
                    check("resp_type", {31'd0, d_ready}, {31'd0, e.is_data});
                    check("resp_data", e.is_data ? dmmload : imemload, e.data);
                end
            end
        end
    end

    task automatic run_until(input int ni, input int nd, input int budget);
        int gi = 0;
        int gd = 0;
        int cyc = 0;
        while ((gi < ni || gd < nd) && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            if (i_ready) begin
                gi++;
                if (gi >= ni) imemRen = 1'b0;
            end
            if (d_ready) begin
                gd++;
                if (gd >= nd) begin
                    dmmRen = 1'b0;
                    dmmWen = 1'b0;
                end
            end
        end
        n_cmp++;
        if (gi < ni || gd < nd) begin
            n_err++;
            $display("FAIL run_until_timeout: got i=%0d d=%0d expected i=%0d d=%0d", gi, gd, ni, nd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            logic [15:0] a;
            a = 16'(i * 4);
            mem[i] = {a, ~a};
        end
        mem[64] = 32'hDEADBEEF;
        nRst = 1'b0;
        imemRen = 0; dmmRen = 0; dmmWen = 0;
        imemaddr = 0; dmmaddr = 0; dmmstore = 0;
        repeat (2) @(negedge clk);
        check("rst_ren", {31'd0, Ren}, 32'd0);
        check("rst_wen", {31'd0, Wen}, 32'd0);
        check("rst_ready", {30'd0, i_ready, d_ready}, 32'd0);
        check("rst_ramaddr", ramaddr, 32'd0);
        check("rst_ramstore", ramstore, 32'd0);
        check("rst_imemload", imemload, 32'd0);
        check("rst_dmmload", dmmload, 32'd0);
        @(posedge clk); #1;
        nRst = 1'b1;

        // single fetch, latency check
        @(posedge clk); #1;
        imemRen = 1; imemaddr = 32'h100;
        sb.push_back('{1'b0, 32'hDEADBEEF});
        @(posedge clk); #1;
        imemRen = 0;
        check("f_c1_ren", {31'd0, Ren}, 32'd1);
        check("f_c1_wen", {31'd0, Wen}, 32'd0);
        check("f_c1_ramaddr", ramaddr, 32'h100);
        check("f_c1_ramstore", ramstore, 32'd0);
        @(posedge clk); #1;
        check("f_c2_iready", {31'd0, i_ready}, 32'd1);
        check("f_c2_ren", {31'd0, Ren}, 32'd0);
        @(posedge clk); #1;
        check("f_c3_iready", {31'd0, i_ready}, 32'd0);

        // simultaneous: data first, then fetch
        @(posedge clk); #1;
        imemRen = 1; imemaddr = 32'h104;
        dmmRen = 1; dmmaddr = 32'h400;
        sb.push_back('{1'b1, 32'h0400FBFF});
        sb.push_back('{1'b0, 32'h0104FEFB});
        run_until(1, 1, 50);

        // write with 3 wait states; address changes mid-transaction
        @(posedge clk); #1;
        wait_states = 3;
        dmmWen = 1; dmmaddr = 32'h200; dmmstore = 32'h12345678;
        sb.push_back('{1'b1, 32'h0400FBFF});
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            if (c == 1) dmmWen = 0;
            if (c == 2) dmmaddr = 32'h300;
            check("w_wen", {31'd0, Wen}, 32'd1);
            check("w_ren", {31'd0, Ren}, 32'd0);
            check("w_ramaddr", ramaddr, 32'h200);
            check("w_ramstore", ramstore, 32'h12345678);
            check("w_dready_early", {31'd0, d_ready}, 32'd0);
        end
        @(posedge clk); #1;
        check("w_c5_dready", {31'd0, d_ready}, 32'd1);
        check("w_c5_wen", {31'd0, Wen}, 32'd0);
        @(posedge clk); #1;
        check("w_c6_dready", {31'd0, d_ready}, 32'd0);
        wait_states = 0;

        // starvation: four data grants, then a forced fetch, then data resumes
        @(posedge clk); #1;
        dmmRen = 1; dmmaddr = 32'h400;
        imemRen = 1; imemaddr = 32'h108;
        for (int k = 0; k < 4; k++) sb.push_back('{1'b1, 32'h0400FBFF});
        sb.push_back('{1'b0, 32'h0108FEF7});
        for (int k = 0; k < 2; k++) sb.push_back('{1'b1, 32'h0400FBFF});
        run_until(1, 6, 100);

        // reset during a stalled read
        @(posedge clk); #1;
        wait_states = 10;
        dmmRen = 1; dmmaddr = 32'h500;
        @(posedge clk); #1;
        check("r_c1_ren", {31'd0, Ren}, 32'd1);
        @(posedge clk); #2;
        nRst = 1'b0;
        #1;
        check("r_async_ren", {31'd0, Ren}, 32'd0);
        check("r_async_dready", {31'd0, d_ready}, 32'd0);
        check("r_async_dmmload", dmmload, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        nRst = 1'b1;
        wait_states = 0;
        dmmaddr = 32'h200;
        sb.push_back('{1'b1, 32'h12345678});
        run_until(0, 1, 50);

        repeat (3) @(posedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_fsm.md
Name: mem_arbiter_fsm

Overview:
Sequencing arbiter between the request unit's instruction-fetch and data-access ports and the single shared RAM port. Accepts at most one transaction at a time and drives Ren/Wen/ramaddr/ramstore to the RAM. Waits out the RAM's busy_o handshake, captures ramload, and returns a one-cycle ready pulse to the granted requester. Data has priority over fetch, with a starvation limiter that guarantees forward progress for fetch.

Parameters:
ADDR_W, 32, address width (word_t)
DATA_W, 32, data width (word_t)
STARVE_LIM, 4, consecutive data grants allowed while a fetch is pending before fetch is forced (1..15)

Ports:
clk  in  1  system clock, rising edge
nRst  in  1  asynchronous active-low reset
imemRen  in  1  fetch request, held until i_ready
imemaddr  in  ADDR_W  fetch address
dmmRen  in  1  data read request, held until d_ready
dmmWen  in  1  data write request, held until d_ready
dmmaddr  in  ADDR_W  data address
dmmstore  in  DATA_W  write data
busy_o  in  1  RAM busy; 0 means the current operation completes this cycle
ramload  in  DATA_W  RAM read data, valid when busy_o=0 during a read
i_ready  out  1  one-cycle fetch completion pulse
d_ready  out  1  one-cycle data completion pulse
imemload  out  DATA_W  fetched word
dmmload  out  DATA_W  loaded word
Ren  out  1  RAM read enable
Wen  out  1  RAM write enable
ramaddr  out  ADDR_W  RAM address
ramstore  out  DATA_W  RAM write data

Behaviour:
- Reset (async, nRst=0): state=IDLE; all outputs 0; starve counter=0; latched address/data=0. Any in-flight transaction is abandoned and Ren/Wen drop immediately, not at the next edge.
- States: IDLE, IACC, DACC, RESP.
- IDLE grant decision, registered at the clock edge:
  - Data is pending if dmmRen|dmmWen.
  - If data is pending and (imemRen=0 or starve<STARVE_LIM): go to DACC.
  - Else if imemRen: go to IACC.
  - Else stay in IDLE.
  - On the grant edge, latch the address, write data, and op (dmmWen=1 means write, which wins over dmmRen if both are set).
- Starve counter:
  - Increments on each DACC grant taken while imemRen=1, saturating at STARVE_LIM.
  - Clears on any IACC grant, and on any DACC grant with imemRen=0.
- IACC/DACC:
  - Ren (read) or Wen (write) is held high for the whole state. Ren and Wen are never both 1.
  - ramaddr and ramstore are driven from latched values. Requester inputs changing mid-transaction have no effect.
  - ramstore=0 for reads.
- Completion:
  - The first cycle in IACC/DACC with busy_o=0 completes the transaction.
  - On that edge, capture ramload into imemload (fetch) or dmmload (data read); dmmload is unchanged on writes.
  - Go to RESP; Ren/Wen deassert.
- RESP: i_ready or d_ready is 1 for exactly this one cycle. No grant is taken in RESP; return to IDLE next cycle. This stops a still-held request from being re-granted in its own ready cycle.
- imemload and dmmload hold their value until the next capture of the same type.
- Latency: request seen in IDLE at cycle 0, Ren in cycle 1. With busy_o=0 in cycle 1, ready is in cycle 2, and IDLE resumes in cycle 3. Each busy_o=1 cycle adds 1.
- Requests that drop before their grant are simply not served. Dropping a request after its grant does not abort the transaction.
- No timeout: busy_o stuck high holds the state indefinitely.

Test Plan:
- Single fetch: imemRen=1, imemaddr=0x100, busy_o=0, ramload=0xDEADBEEF -> Ren=1 with ramaddr=0x100 in cycle 1; i_ready=1 and imemload=0xDEADBEEF in cycle 2; IDLE in cycle 3.
- Write with wait states: dmmWen=1, dmmaddr=0x200, dmmstore=0x12345678, busy_o=1 for 3 cycles -> Wen held 4 cycles with ramstore=0x12345678; d_ready pulses exactly once, in cycle 5; Ren stays 0 throughout.
- Simultaneous requests: imemRen=1 and dmmRen=1 in the same cycle -> DACC granted first; after d_ready, IACC is granted on the next IDLE; i_ready follows.
- Starvation: dmmRen held continuously, imemRen=1, STARVE_LIM=4, busy_o=0 -> four d_ready pulses, then one i_ready, then data resumes.
- Mid-operation reset: nRst pulled low while Ren=1 and busy_o=1 -> Ren=0 asynchronously, no ready pulse; after release, a held request re-arbitrates from IDLE.
- Input stability: change dmmaddr 0x200->0x300 during DACC wait states -> ramaddr stays 0x200 until completion.
